// File: rtl/dcm_prog_if.sv
// Request/feedback bundle between a requester, dcm_prog_ctrl and the clock divider.
interface dcm_prog_if;
  logic       inc_req;
  logic       dec_req;
  logic       load_req;
  logic [2:0] load_val;
  logic [2:0] prog_out_fb;
  logic       update;
  logic [2:0] prog_in;
  logic [2:0] cur_prog;
  logic       busy;
  logic       done;
  logic       err;
  logic       rej;

  modport master (
    output inc_req, dec_req, load_req, load_val, prog_out_fb,
    input  update, prog_in, cur_prog, busy, done, err, rej
  );

  modport slave (
    input  inc_req, dec_req, load_req, load_val, prog_out_fb,
    output update, prog_in, cur_prog, busy, done, err, rej
  );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// Arbitrates inc/dec/load requests for the divider code, pulses update, then confirms
// the change through prog_out feedback with a timeout.
module dcm_prog_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 8
) (
  input logic       clk,
  input logic       rst,
  dcm_prog_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         prog_in_q, prog_in_d;
  logic [2:0]         cur_prog_q, cur_prog_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               update_q, update_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rej_q, rej_d;

  logic               accept;
  logic [2:0]         target;
  logic               any_req;

  always_comb begin
    state_d    = state_q;
    prog_in_d  = prog_in_q;
    cur_prog_d = cur_prog_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    accept     = 1'b0;
    target     = cur_prog_q;
    any_req    = bus.load_req | bus.inc_req | bus.dec_req;

    unique case (state_q)
      StIdle: begin
        // inc and dec together cancel unless a load overrides both
        if (bus.load_req) begin
          accept = 1'b1;
          target = bus.load_val;
        end else if (bus.inc_req && !bus.dec_req) begin
          accept = 1'b1;
          target = (cur_prog_q == 3'd7) ? 3'd7 : cur_prog_q + 3'd1;
        end else if (bus.dec_req && !bus.inc_req) begin
          accept = 1'b1;
          target = (cur_prog_q == 3'd0) ? 3'd0 : cur_prog_q - 3'd1;
        end
        if (accept) begin
          err_d     = 1'b0;
          prog_in_d = target;
          state_d   = (target == cur_prog_q) ? StDone : StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.prog_out_fb == prog_in_q) begin
          cur_prog_d = prog_in_q;
          state_d    = StDone;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d      = 1'b1;
          cur_prog_d = bus.prog_out_fb;
          state_d    = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    rej_d    = (state_q != StIdle) && any_req;
    update_d = (state_d == StIssue);
    done_d   = (state_d == StDone);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      prog_in_q  <= 3'd0;
      cur_prog_q <= 3'd0;
      cnt_q      <= '0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_in_q  <= prog_in_d;
      cur_prog_q <= cur_prog_d;
      cnt_q      <= cnt_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rej_q      <= rej_d;
    end
  end

  assign bus.update   = update_q;
  assign bus.prog_in  = prog_in_q;
  assign bus.cur_prog = cur_prog_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rej      = rej_q;

endmodule

// File: doc/dcm_prog_ctrl.md
Name: dcm_prog_ctrl

Overview:
Configuration sequencer for the clock divider block (dcm). It accepts slow-clock frequency change requests from three sources: increment, decrement and direct load. It arbitrates them and drives the divider's update/prog_in pair with a one-cycle update pulse. It then confirms the change by watching the divider's prog_out feedback, and reports done or timeout error to the requester.

Parameters:
TIMEOUT_CYC, 16, max clk cycles spent in WAIT for prog_out_fb to match the target before error (>=2)
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clk  input  1  system clock (100 MHz), all logic on posedge
rst  input  1  reset, asynchronous, active-high
inc_req  input  1  single-cycle strobe: target = cur_prog+1, saturating at 7
dec_req  input  1  single-cycle strobe: target = cur_prog-1, saturating at 0
load_req  input  1  single-cycle strobe: target = load_val
load_val  input  3  direct target code (0..7)
prog_out_fb  input  3  feedback from divider prog_out
update  output  1  one-cycle pulse to divider update
prog_in  output  3  target code to divider prog_in; held stable from ISSUE until state leaves WAIT
cur_prog  output  3  last confirmed divider code
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a request completes successfully
err  output  1  sticky timeout flag; cleared by reset or the next accepted request
rej  output  1  one-cycle pulse when any request strobe arrives while busy=1 (request dropped)

Behaviour:
- Reset (async, immediate): state=IDLE, update=0, prog_in=0, cur_prog=0, busy=0, done=0, err=0, rej=0, timeout counter=0.
- States: IDLE, ISSUE, WAIT, DONE. All outputs registered.
- IDLE: samples strobes each cycle. Priority is load_req > inc_req > dec_req. inc_req and dec_req together without load_req cancel: nothing is accepted and rej=0.
- Accepted request: err<=0, target latched into prog_in.
  - target == cur_prog (incl. inc at 7, dec at 0, load of the current value): go to DONE; no update pulse.
  - Otherwise: go to ISSUE.
- ISSUE: update=1 for exactly this cycle, counter<=0, then go to WAIT.
- WAIT: update=0, counter increments each cycle.
  - prog_out_fb == prog_in: cur_prog<=prog_in, go to DONE.
  - Else if counter == TIMEOUT_CYC-1: err<=1, cur_prog<=prog_out_fb (resync to actual divider state), go to IDLE, no done pulse.
- DONE: done=1 for one cycle, then go to IDLE. busy=1 in this cycle.
- Latency, with the divider registering prog on the clock after update:
  - strobe at edge N
  - update high during cycle N+1
  - match seen in WAIT at N+2
  - done high during cycle N+3
  - Skip path: done high during cycle N+1.
- Strobes during ISSUE/WAIT/DONE: ignored, rej pulses the following cycle, state and targets untouched. A strobe coincident with the return to IDLE (same edge as the DONE→IDLE transition) is rejected.
- Arithmetic: 3-bit unsigned, saturating at both ends; no wrap-around (7+1=7, 0-1=0).
- prog_out_fb changes while in IDLE: ignored; cur_prog only changes on a DONE entry or a timeout.
- Reset mid-transaction: return to IDLE immediately. No done or err is produced for the aborted request.

Test Plan:
- Reset, then inc_req pulse → update pulse one cycle later with prog_in=1; fb model goes to 1 → done at N+3, cur_prog=1, busy high N+1..N+3.
- cur_prog=7, inc_req → no update, done at N+1, cur_prog stays 7. Same for dec_req at cur_prog=0.
- load_req(load_val=5) and inc_req in the same cycle with cur_prog=1 → prog_in=5, single update, cur_prog=5 after done.
- inc_req during WAIT → rej pulse one cycle later, transaction unaffected, exactly one update total.
- fb held at 2 while target=3, TIMEOUT_CYC=16 → err=1 after 16 WAIT cycles, cur_prog=2, no done. The next accepted dec_req clears err.
- rst asserted during WAIT → all outputs 0 asynchronously; after release, IDLE and cur_prog=0.
